// File: rtl/mult_mix_seq.sv
// Time-multiplexed multi-channel multiply-accumulate mixer: one shared signed x unsigned
// multiplier walks all channels, then shifts, saturates and presents one mixed sample.
module mult_mix_seq #(
    parameter int SIG_W     = 16,
    parameter int COEF_W    = 16,
    parameter int NUM_CH    = 3,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 16,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iStart,
    output logic              oBusy,
    output logic [CH_W-1:0]   oChSel,
    input  logic [SIG_W-1:0]  iSignal,
    input  logic [COEF_W-1:0] iCoef,
    output logic [OUT_W-1:0]  oOut,
    output logic              oValid,
    output logic              oClip
);

    localparam int PROD_W = SIG_W + COEF_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                    state_q, state_d;
    logic [CH_W-1:0]           ch_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic signed [PROD_W-1:0]  prod_d;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   shifted;
    logic                      acc_first_q;
    logic                      acc_en;
    logic [OUT_W-1:0]          out_q;
    logic [OUT_W-1:0]          sat_out;
    logic                      sat_clip;
    logic                      valid_q;
    logic                      clip_q;

    // Zero-extend the coefficient so its full unsigned range survives the signed multiply.
    assign prod_d   = PROD_W'($signed(iSignal)) * PROD_W'($signed({1'b0, iCoef}));
    assign prod_ext = ACC_W'(prod_q);
    assign shifted  = acc_q >>> OUT_SHIFT;

    // prod_q holds a fresh product on every RUN edge after the first, and once more in DRAIN.
    assign acc_en = ((state_q == StRun) && (ch_q != '0)) || (state_q == StDrain);

    always_comb begin
        sat_out  = shifted[OUT_W-1:0];
        sat_clip = 1'b0;
        if (shifted > OUT_MAX) begin
            sat_out  = {1'b0, {(OUT_W-1){1'b1}}};
            sat_clip = 1'b1;
        end else if (shifted < OUT_MIN) begin
            sat_out  = {1'b1, {(OUT_W-1){1'b0}}};
            sat_clip = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (iStart) state_d = StRun;
            StRun:   if (ch_q == LAST_CH) state_d = StDrain;
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q        <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            acc_first_q <= 1'b0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            clip_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (state_q == StIdle && iStart) begin
                acc_first_q <= 1'b1;
            end
            if (state_q == StRun) begin
                prod_q <= prod_d;
                ch_q   <= (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
            end
            if (acc_en) begin
                acc_q       <= acc_first_q ? prod_ext : acc_q + prod_ext;
                acc_first_q <= 1'b0;
            end
            if (state_q == StDone) begin
                out_q   <= sat_out;
                clip_q  <= sat_clip;
                valid_q <= 1'b1;
            end
        end
    end

    assign oBusy  = (state_q != StIdle);
    assign oChSel = ch_q;
    assign oOut   = out_q;
    assign oValid = valid_q;
    assign oClip  = clip_q;

endmodule

// File: tb/tb_mult_mix_seq.sv
// Self-checking bench for mult_mix_seq: directed corner cases plus randomized passes
// compared against an arithmetic sum-of-products model.
module tb_mult_mix_seq;

    localparam int NCH = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iStart = 1'b0;
    logic        oBusy;
    logic [1:0]  oChSel;
    logic [15:0] iSignal;
    logic [15:0] iCoef;
    logic [15:0] oOut;
    logic        oValid;
    logic        oClip;

    logic signed [15:0] sig_a [4];
    logic        [15:0] coef_a [4];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Parent drives the selected channel combinationally.
    assign iSignal = sig_a[oChSel];
    assign iCoef   = coef_a[oChSel];

    mult_mix_seq #(
        .SIG_W    (16),
        .COEF_W   (16),
        .NUM_CH   (NCH),
        .OUT_W    (16),
        .OUT_SHIFT(16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .iStart (iStart),
        .oBusy  (oBusy),
        .oChSel (oChSel),
        .iSignal(iSignal),
        .iCoef  (iCoef),
        .oOut   (oOut),
        .oValid (oValid),
        .oClip  (oClip)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(output logic [15:0] out, output logic clip);
        longint acc = 0;
        longint sh;
        for (int c = 0; c < NCH; c++) begin
            acc += longint'(sig_a[c]) * longint'(coef_a[c]);
        end
        sh = acc >>> 16;
        clip = 1'b0;
        if (sh > 32767) begin
            sh = 32767;
            clip = 1'b1;
        end else if (sh < -32768) begin
            sh = -32768;
            clip = 1'b1;
        end
        out = sh[15:0];
    endfunction

    task automatic set_all(input logic [15:0] s, input logic [15:0] k);
        for (int c = 0; c < 4; c++) begin
            sig_a[c]  = s;
            coef_a[c] = k;
        end
    endtask

    task automatic randomize_chans();
        for (int c = 0; c < NCH; c++) begin
            sig_a[c]  = 16'($urandom);
            coef_a[c] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) sig_a[c] = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
        end
    endtask

    // One start pulse from idle; checks channel sequence, busy, latency and result.
    task automatic run_pass(input string tag);
        logic [15:0] eo;
        logic        ec;
        int          n;
        model(eo, ec);
        @(posedge clk); #1 iStart = 1'b1;
        @(posedge clk); #1 iStart = 1'b0;
        n = 0;
        check({tag, "_chsel"}, longint'(oChSel), 0);
        while (!oValid && n < 20) begin
            @(posedge clk); #1;
            n++;
            check({tag, "_chsel"}, longint'(oChSel), (n < NCH) ? n : 0);
            check({tag, "_busy"}, longint'(oBusy), (n < NCH + 2) ? 1 : 0);
        end
        check({tag, "_latency"}, n, NCH + 2);
        check({tag, "_out"}, longint'(oOut), longint'(eo));
        check({tag, "_clip"}, longint'(oClip), longint'(ec));
    endtask

    initial begin
        logic [15:0] eo;
        logic        ec;
        int          nval;
        int          k;
        int          last;

        set_all(16'h0, 16'h0);

        // Reset held with start asserted
        iStart = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", longint'(oOut), 0);
        check("rst_valid", longint'(oValid), 0);
        check("rst_clip", longint'(oClip), 0);
        check("rst_busy", longint'(oBusy), 0);
        check("rst_chsel", longint'(oChSel), 0);
        @(negedge clk);
        iStart = 1'b0;
        rst_n  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_busy", longint'(oBusy), 0);
        check("post_rst_valid", longint'(oValid), 0);

        set_all(16'h4000, 16'h8000);
        run_pass("basic");
        check("basic_const", longint'(oOut), 16'h6000);

        set_all(16'h8000, 16'hFFFF);
        run_pass("neg_sat");
        check("neg_sat_const", longint'(oOut), 16'h8000);
        check("neg_sat_clip_const", longint'(oClip), 1);

        set_all(16'h7FFF, 16'hFFFF);
        run_pass("pos_sat");
        check("pos_sat_const", longint'(oOut), 16'h7FFF);

        sig_a[0] = 16'h7FFF; coef_a[0] = 16'h1000;
        sig_a[1] = 16'h8001; coef_a[1] = 16'h1000;
        sig_a[2] = 16'hFFFF; coef_a[2] = 16'h0001;
        run_pass("floor");
        check("floor_const", longint'(oOut), 16'hFFFF);
        check("floor_clip_const", longint'(oClip), 0);

        // Extra start pulses while busy must be ignored
        randomize_chans();
        model(eo, ec);
        nval = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (oValid) begin
                nval++;
                check("ignore_out", longint'(oOut), longint'(eo));
            end
            iStart = (i == 0 || i == 2 || i == 3);
        end
        iStart = 1'b0;
        check("ignore_valid_count", nval, 1);

        // Start held high: back-to-back passes
        randomize_chans();
        @(posedge clk); #1 iStart = 1'b1;
        k = 0;
        last = 0;
        for (int cyc = 0; cyc < 60 && k < 5; cyc++) begin
            @(posedge clk); #1;
            if (oValid) begin
                model(eo, ec);
                check("held_out", longint'(oOut), longint'(eo));
                check("held_clip", longint'(oClip), longint'(ec));
                if (k > 0) check("held_period", cyc - last, NCH + 3);
                last = cyc;
                k++;
                randomize_chans();
                if (k == 5) iStart = 1'b0;
            end
        end
        iStart = 1'b0;
        check("held_count", k, 5);

        // Abort mid-pass with reset
        set_all(16'h8000, 16'hFFFF);
        run_pass("pre_abort");
        set_all(16'h7FFF, 16'hFFFF);
        @(posedge clk); #1 iStart = 1'b1;
        @(posedge clk); #1 iStart = 1'b0;
        @(posedge clk); #1;
        check("abort_chsel_before", longint'(oChSel), 1);
        rst_n = 1'b0;
        #1;
        check("abort_out", longint'(oOut), 0);
        check("abort_clip", longint'(oClip), 0);
        check("abort_busy", longint'(oBusy), 0);
        check("abort_chsel", longint'(oChSel), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nval = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (oValid) nval++;
        end
        check("abort_no_valid", nval, 0);
        sig_a[0] = 16'h1234; coef_a[0] = 16'h0100;
        sig_a[1] = 16'hF000; coef_a[1] = 16'h0010;
        sig_a[2] = 16'h0001; coef_a[2] = 16'hFFFF;
        run_pass("fresh");

        for (int r = 0; r < 8; r++) begin
            randomize_chans();
            run_pass("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
